projectile_pool: RTL

Multi-slot projectile manager, the successor to the single-projectile block. It holds NUM_PROJ independent projectiles per shooter. Each frame it allocates, moves, retires and hit-tests them against one target box, and it enforces a fire cooldown. It sits between the player/npc blocks, which supply shooter position, fire and direction, and the color_mapper, which consumes is_proj. Hit results feed the health logic.

---
 rtl/ff_proj_pkg.sv | 31 +++
 rtl/proj_slot.sv | 89 ++++++++
 rtl/projectile_pool.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ff_proj_pkg.sv
// rtl/ff_proj_pkg.sv - shared types and slot allocator helper for the projectile pool
package ff_proj_pkg;

    localparam int SLOT_COORD_W = 10;
    localparam int MAX_SLOTS    = 16;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef struct packed {
        logic                    active;
        logic [SLOT_COORD_W-1:0] x;
        logic [SLOT_COORD_W-1:0] y;
        dir_t                    dir;
    } proj_slot_t;

    // Returns {found, index} of the lowest clear bit among the first n bits.
    function automatic logic [4:0] find_first_zero(input logic [MAX_SLOTS-1:0] mask, input int n);
        logic [4:0] r;
        r = '0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (i < n && !mask[i]) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/proj_slot.sv
// rtl/proj_slot.sv - one projectile slot: state register, hit/edge/move logic, pixel term
module proj_slot
    import ff_proj_pkg::*;
#(
    parameter int COORD_W   = SLOT_COORD_W,
    parameter int SCREEN_W  = 640,
    parameter int PROJ_SIZE = 4,
    parameter int STEP      = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               tick,
    input  logic               load,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               spawn_dir,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    input  logic [COORD_W-1:0] target_xs,
    input  logic [COORD_W-1:0] target_ys,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               active,
    output logic               hit,
    output logic               is_proj
);

    localparam int EW = COORD_W + 1;

    proj_slot_t slot_q, slot_d;

    // One extra bit on every operand so sums never wrap.
    logic [EW-1:0] x_e, y_e, tx_e, ty_e, txs_e, tys_e, dx_e, dy_e;
    logic          hit_zone, edge_right, edge_left, at_edge;

    assign x_e   = {1'b0, slot_q.x};
    assign y_e   = {1'b0, slot_q.y};
    assign tx_e  = {1'b0, target_x};
    assign ty_e  = {1'b0, target_y};
    assign txs_e = {1'b0, target_xs};
    assign tys_e = {1'b0, target_ys};
    assign dx_e  = {1'b0, draw_x};
    assign dy_e  = {1'b0, draw_y};

    assign hit_zone   = (x_e < tx_e + txs_e) && (x_e + EW'(PROJ_SIZE) > tx_e) &&
                        (y_e < ty_e + tys_e) && (y_e + EW'(PROJ_SIZE) > ty_e);
    assign edge_right = (x_e + EW'(STEP) + EW'(PROJ_SIZE)) > EW'(SCREEN_W);
    assign edge_left  = x_e < EW'(STEP);
    assign at_edge    = (slot_q.dir == DIR_RIGHT) ? edge_right : edge_left;

    // A freshly loaded slot is inactive at tick start, so it never hits on its spawn tick.
    assign hit    = tick && slot_q.active && hit_zone;
    assign active = slot_q.active;

    assign is_proj = slot_q.active &&
                     (x_e <= dx_e) && (dx_e < x_e + EW'(PROJ_SIZE)) &&
                     (y_e <= dy_e) && (dy_e < y_e + EW'(PROJ_SIZE));

    // Tick update: load beats everything; then hit, edge retire, move in priority order.
    always_comb begin
        slot_d = slot_q;
        if (tick) begin
            if (load) begin
                slot_d.active = 1'b1;
                slot_d.x      = spawn_x;
                slot_d.y      = spawn_y;
                slot_d.dir    = dir_t'(spawn_dir);
            end else if (slot_q.active) begin
                if (hit_zone || at_edge) begin
                    slot_d.active = 1'b0;
                end else if (slot_q.dir == DIR_RIGHT) begin
                    slot_d.x = slot_q.x + COORD_W'(STEP);
                end else begin
                    slot_d.x = slot_q.x - COORD_W'(STEP);
                end
            end
        end
    end

    // Slot state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// rtl/projectile_pool.sv - multi-slot projectile manager with fire cooldown and hit counting
module projectile_pool
    import ff_proj_pkg::*;
#(
    parameter int NUM_PROJ        = 4,
    parameter int COORD_W         = SLOT_COORD_W,
    parameter int SCREEN_W        = 640,
    parameter int PROJ_SIZE       = 4,
    parameter int STEP            = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_clk,
    input  logic                          fire,
    input  logic                          fire_dir,
    input  logic [COORD_W-1:0]            Shooter_X,
    input  logic [COORD_W-1:0]            Shooter_Y,
    input  logic [COORD_W-1:0]            Target_X,
    input  logic [COORD_W-1:0]            Target_Y,
    input  logic [COORD_W-1:0]            Target_X_Size,
    input  logic [COORD_W-1:0]            Target_Y_Size,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    output logic                          is_proj,
    output logic [NUM_PROJ-1:0]           active_mask,
    output logic                          hit_pulse,
    output logic [$clog2(NUM_PROJ+1)-1:0] hit_count,
    output logic                          fire_dropped
);

    localparam int CNT_W = $clog2(NUM_PROJ + 1);
    localparam int CD_W  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    logic             frame_prev_q, fire_prev_q;
    logic             fire_pending_q, fire_pending_d;
    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             fire_dropped_q, fire_dropped_d;

    logic                tick, fire_edge, alloc_try, alloc_go, alloc_drop;
    logic [4:0]          ffz;
    logic [NUM_PROJ-1:0] active_vec, hit_vec, is_proj_vec, load_vec;
    logic [CNT_W-1:0]    hit_sum;

    assign tick       = frame_clk && !frame_prev_q;
    assign fire_edge  = fire && !fire_prev_q;

    // Allocation decisions use the start-of-tick mask, so a slot freed this tick stays unused.
    assign ffz        = find_first_zero(16'(active_vec), NUM_PROJ);
    assign alloc_try  = tick && fire_pending_q && (cooldown_q == '0);
    assign alloc_go   = alloc_try && ffz[4];
    assign alloc_drop = alloc_try && !ffz[4];

    for (genvar g = 0; g < NUM_PROJ; g++) begin : g_slot
        assign load_vec[g] = alloc_go && (ffz[3:0] == 4'(g));

        proj_slot #(
            .COORD_W  (COORD_W),
            .SCREEN_W (SCREEN_W),
            .PROJ_SIZE(PROJ_SIZE),
            .STEP     (STEP)
        ) u_slot (
            .Clk      (Clk),
            .Reset    (Reset),
            .tick     (tick),
            .load     (load_vec[g]),
            .spawn_x  (Shooter_X),
            .spawn_y  (Shooter_Y),
            .spawn_dir(fire_dir),
            .target_x (Target_X),
            .target_y (Target_Y),
            .target_xs(Target_X_Size),
            .target_ys(Target_Y_Size),
            .draw_x   (DrawX),
            .draw_y   (DrawY),
            .active   (active_vec[g]),
            .hit      (hit_vec[g]),
            .is_proj  (is_proj_vec[g])
        );
    end

    // Pending fire, cooldown and registered tick results.
    always_comb begin
        fire_pending_d = tick ? fire_edge : (fire_pending_q || fire_edge);
        cooldown_d     = cooldown_q;
        if (tick) begin
            if (alloc_go) begin
                cooldown_d = CD_W'(COOLDOWN_FRAMES);
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - CD_W'(1);
            end
        end
        hit_sum = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            hit_sum = hit_sum + CNT_W'(hit_vec[i]);
        end
        hit_count_d    = tick ? hit_sum : '0;
        hit_pulse_d    = tick && (hit_sum != '0);
        fire_dropped_d = alloc_drop;
    end

    // Control registers; edge detectors track the live inputs during reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_prev_q   <= frame_clk;
            fire_prev_q    <= fire;
            fire_pending_q <= 1'b0;
            cooldown_q     <= '0;
            hit_pulse_q    <= 1'b0;
            hit_count_q    <= '0;
            fire_dropped_q <= 1'b0;
        end else begin
            frame_prev_q   <= frame_clk;
            fire_prev_q    <= fire;
            fire_pending_q <= fire_pending_d;
            cooldown_q     <= cooldown_d;
            hit_pulse_q    <= hit_pulse_d;
            hit_count_q    <= hit_count_d;
            fire_dropped_q <= fire_dropped_d;
        end
    end

    assign active_mask  = active_vec;
    assign is_proj      = |is_proj_vec;
    assign hit_pulse    = hit_pulse_q;
    assign hit_count    = hit_count_q;
    assign fire_dropped = fire_dropped_q;

endmodule
